id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameters: none; widths are fixed at 32-bit data and 5-bit register numbers.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports listed as name direction width meaning:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs_data, id_rt_data  in  32  register-file read values
- id_rs, id_rt, id_rd  in  5  register numbers
- id_imm  in  32  sign-extended immediate
- id_alu_src  in  1  1 = B from immediate
- id_alu_ctrl  in  2  00 add, 01 sub, 10 use funct, 11 or
- id_funct  in  6  R-type funct field
- id_reg_dst  in  1  1 = dest rd, 0 = dest rt
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  branch taken, kill decode instruction
- exm_reg_write, exm_rd, exm_result  in  1/5/32  EX/MEM writeback info
- mwb_reg_write, mwb_rd, mwb_result  in  1/5/32  MEM/WB writeback info
- alu_a, alu_b  out  32  ALU operands (forwarded)
- alu_op  out  3  ALU operation code
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control
- ex_dest  out  5  destination register
- ex_store_data  out  32  forwarded rt value for stores
- ex_illegal  out  1  registered unknown-funct flag
- stall_id  out  1  combinational: hold PC and IF/ID

Function
REQ-003 Pipeline register SHALL capture decode fields on every rising edge; latency decode->EX outputs is one cycle.
REQ-004 alu_op SHALL be decoded before the register: ctrl 00->010, 01->110, 11->001; ctrl 10 with funct 100000->010, 100010->110, 100100->000, 100101->001, 100111->100, 101010->111.
REQ-005 ctrl 10 with any other funct SHALL register alu_op=010 and ex_illegal=1 (only when id_valid=1).
REQ-006 ex_dest SHALL register id_rd when id_reg_dst=1, else id_rt.
REQ-007 stall_id SHALL be 1 when ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | ex_dest==id_rt); else 0.
REQ-008 Next-cycle priority SHALL be rst > flush > stall_id > normal load.
REQ-009 Flush or stall SHALL load a bubble: all registered outputs to reset values.
REQ-010 id_valid=0 SHALL load a bubble.
REQ-011 Forwarding SHALL be combinational on registered rs/rt values: EX/MEM match wins over MEM/WB match; no match uses the registered value.
REQ-012 A match SHALL require the stage's reg_write=1, rd!=0 and rd equal to the registered rs (or rt).
REQ-013 alu_a SHALL be forwarded rs; alu_b SHALL be registered imm when alu_src=1, else forwarded rt.
REQ-014 ex_store_data SHALL always be forwarded rt, independent of alu_src.
REQ-015 Register 0 SHALL never be forwarded; its value passes through as read.

Reset
REQ-016 On rst all registered state SHALL clear: ex_valid, control bits, ex_illegal, ex_dest, stored data = 0; alu_op = 010.
REQ-017 Reset mid-stall SHALL deassert stall_id next cycle, since ex_valid=0.

Structure
REQ-018 The ALU op codes, ctrl encodings and funct constants SHALL live in the shared CPU package, used by both this block and the ALU.
REQ-019 The forwarding selection SHALL be one sub-module, fwd_mux, instantiated twice (rs, rt).

Verification
REQ-020 Forward EX/MEM: reg rs=5 stored 0x10; exm_reg_write=1, exm_rd=5, exm_result=0x99 -> alu_a=0x99.
REQ-021 Priority: exm_rd=mwb_rd=7, results 0x1/0x2, both write -> operand 0x1; exm_reg_write=0 -> 0x2.
REQ-022 Load-use: EX holds lw dest 8; decode add rs=8 -> stall_id=1, next cycle ex_valid=0; following cycle add loads, alu_a from MEM/WB.
REQ-023 Flush and stall together: flush=1, stall_id=1 -> bubble, ex_valid=0, no double-issue after release.
REQ-024 Decode: ctrl 10, funct 101010 -> alu_op=111; funct 000011 -> alu_op=010, ex_illegal=1; rd=0 writer -> no forwarding.
REQ-025 Reset: assert rst during load-use stall -> next cycle all outputs at REQ-016 values, stall_id=0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared CPU package: ALU operation codes, ALU control encodings and R-type
// funct constants used by the ID/EX stage and by the ALU.
package id_ex_stage_pkg;

    // ALU operation codes seen by the ALU
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_NOR = 3'b100,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Main-decoder ALU control field
    typedef enum logic [1:0] {
        CTRL_ADD   = 2'b00,
        CTRL_SUB   = 2'b01,
        CTRL_FUNCT = 2'b10,
        CTRL_OR    = 2'b11
    } alu_ctrl_e;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // Register number that is hard-wired to zero and never forwarded
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding selector for one source register of the EX stage.
// EX/MEM has priority over MEM/WB; register 0 is never forwarded.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [4:0]  src_reg,
    input  logic [31:0] reg_data,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic [31:0] data
);

    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = exm_reg_write && (exm_rd != REG_ZERO) && (exm_rd == src_reg);
    assign mwb_hit = mwb_reg_write && (mwb_rd != REG_ZERO) && (mwb_rd == src_reg);

    // Pick the youngest in-flight producer, else the value read in decode
    always_comb begin
        data = reg_data;
        if (exm_hit) begin
            data = exm_result;
        end else if (mwb_hit) begin
            data = mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-op decode in front, load-use hazard
// detection, and EX-side operand forwarding.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_imm,
    input  logic        id_alu_src,
    input  logic [1:0]  id_alu_ctrl,
    input  logic [5:0]  id_funct,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_store_data,
    output logic        ex_illegal,
    output logic        stall_id
);

    alu_op_e     dec_op;
    logic        dec_illegal;
    logic        load_bubble;

    alu_op_e     op_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic        alu_src_q;

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Decode ALU control and funct into the ALU op before the register
    always_comb begin
        dec_op      = ALU_ADD;
        dec_illegal = 1'b0;
        unique case (id_alu_ctrl)
            CTRL_ADD: dec_op = ALU_ADD;
            CTRL_SUB: dec_op = ALU_SUB;
            CTRL_OR:  dec_op = ALU_OR;
            default: begin
                case (id_funct)
                    FUNCT_ADD: dec_op = ALU_ADD;
                    FUNCT_SUB: dec_op = ALU_SUB;
                    FUNCT_AND: dec_op = ALU_AND;
                    FUNCT_OR:  dec_op = ALU_OR;
                    FUNCT_NOR: dec_op = ALU_NOR;
                    FUNCT_SLT: dec_op = ALU_SLT;
                    default: begin
                        dec_op      = ALU_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Load-use hazard: a load in EX whose destination a decode source needs
    assign stall_id = ex_valid && ex_mem_read && (ex_dest != REG_ZERO) && id_valid &&
                      ((ex_dest == id_rs) || (ex_dest == id_rt));

    // Flushed, stalled or empty decode slots all enter EX as a bubble
    assign load_bubble = flush || stall_id || !id_valid;

    // Pipeline register: reset and bubble share the same cleared image
    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_dest      <= '0;
            ex_illegal   <= 1'b0;
            op_q         <= ALU_ADD;
            rs_q         <= '0;
            rt_q         <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            alu_src_q    <= 1'b0;
        end else begin
            ex_valid     <= 1'b1;
            ex_reg_write <= id_reg_write;
            ex_mem_read  <= id_mem_read;
            ex_mem_write <= id_mem_write;
            ex_dest      <= id_reg_dst ? id_rd : id_rt;
            ex_illegal   <= dec_illegal;
            op_q         <= dec_op;
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_q        <= id_imm;
            alu_src_q    <= id_alu_src;
        end
    end

    assign alu_op = op_q;

    fwd_mux u_fwd_rs (
        .src_reg       (rs_q),
        .reg_data      (rs_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .data          (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .src_reg       (rt_q),
        .reg_data      (rt_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .data          (fwd_rt)
    );

    // Stores always need the real rt value, even when B is the immediate
    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding/decode
// scenarios followed by randomized traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm;
    logic        id_alu_src;
    logic [1:0]  id_alu_ctrl;
    logic [5:0]  id_funct;
    logic        id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_dest;
    logic [31:0] ex_store_data;
    logic        ex_illegal;
    logic        stall_id;

    int tests = 0;
    int fails = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_funct(id_funct),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_dest(ex_dest), .ex_store_data(ex_store_data),
        .ex_illegal(ex_illegal), .stall_id(stall_id)
    );

    // Clock
    always #5 clk = ~clk;

    // Model of what the EX stage currently holds: an instruction or nothing
    typedef struct {
        bit          present;
        bit          writes, loads, stores, illegal, uses_imm;
        logic [4:0]  dest, rs, rt;
        logic [2:0]  op;
        logic [31:0] rs_val, rt_val, imm;
    } slot_t;

    slot_t m;

    function automatic slot_t empty_slot();
        slot_t s;
        s.present = 0; s.writes = 0; s.loads = 0; s.stores = 0;
        s.illegal = 0; s.uses_imm = 0;
        s.dest = 0; s.rs = 0; s.rt = 0; s.op = 3'b010;
        s.rs_val = 0; s.rt_val = 0; s.imm = 0;
        return s;
    endfunction

    // Spec decode table: returns {illegal, op}
    function automatic logic [3:0] ref_decode(input logic [1:0] ctrl, input logic [5:0] fn);
        if (ctrl == 2'b00) return 4'b0_010;
        if (ctrl == 2'b01) return 4'b0_110;
        if (ctrl == 2'b11) return 4'b0_001;
        case (fn)
            6'b100000: return 4'b0_010;
            6'b100010: return 4'b0_110;
            6'b100100: return 4'b0_000;
            6'b100101: return 4'b0_001;
            6'b100111: return 4'b0_100;
            6'b101010: return 4'b0_111;
            default:   return 4'b1_010;
        endcase
    endfunction

    // Value an EX operand sees for register r read as v
    function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] v);
        if (r == 0) return v;
        if (exm_reg_write && exm_rd == r) return exm_result;
        if (mwb_reg_write && mwb_rd == r) return mwb_result;
        return v;
    endfunction

    function automatic bit ref_stall();
        return m.present && m.loads && m.dest != 0 && id_valid &&
               (m.dest == id_rs || m.dest == id_rt);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] b_exp;
        b_exp = m.uses_imm ? m.imm : ref_operand(m.rt, m.rt_val);
        chk("ex_valid",      {31'd0, ex_valid},     {31'd0, m.present});
        chk("ex_reg_write",  {31'd0, ex_reg_write}, {31'd0, m.writes});
        chk("ex_mem_read",   {31'd0, ex_mem_read},  {31'd0, m.loads});
        chk("ex_mem_write",  {31'd0, ex_mem_write}, {31'd0, m.stores});
        chk("ex_illegal",    {31'd0, ex_illegal},   {31'd0, m.illegal});
        chk("ex_dest",       {27'd0, ex_dest},      {27'd0, m.dest});
        chk("alu_op",        {29'd0, alu_op},       {29'd0, m.op});
        chk("alu_a",         alu_a,                 ref_operand(m.rs, m.rs_val));
        chk("alu_b",         alu_b,                 b_exp);
        chk("ex_store_data", ex_store_data,         ref_operand(m.rt, m.rt_val));
        chk("stall_id",      {31'd0, stall_id},     {31'd0, ref_stall()});
    endtask

    // Advance one clock, updating the model from the inputs held at the edge
    task automatic step();
        slot_t       nx;
        logic [3:0]  d;
        if (rst || flush || ref_stall() || !id_valid) begin
            nx = empty_slot();
        end else begin
            d           = ref_decode(id_alu_ctrl, id_funct);
            nx.present  = 1;
            nx.writes   = id_reg_write;
            nx.loads    = id_mem_read;
            nx.stores   = id_mem_write;
            nx.illegal  = d[3];
            nx.uses_imm = id_alu_src;
            nx.dest     = id_reg_dst ? id_rd : id_rt;
            nx.rs       = id_rs;
            nx.rt       = id_rt;
            nx.op       = d[2:0];
            nx.rs_val   = id_rs_data;
            nx.rt_val   = id_rt_data;
            nx.imm      = id_imm;
        end
        @(posedge clk);
        #1;
        m = nx;
    endtask

    // Driver: present one decode instruction
    task automatic drive_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic src, input logic [1:0] ctrl, input logic [5:0] fn,
                               input logic dst, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = 32'h0000_0040;
        id_alu_src = src; id_alu_ctrl = ctrl; id_funct = fn; id_reg_dst = dst;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic idle_wb();
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    initial begin
        m = empty_slot();
        rst = 1; flush = 0;
        drive_instr(0, 0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0, 0);
        idle_wb();

        // Reset state
        step();
        rst = 0;
        #1;
        chk("reset_alu_op", {29'd0, alu_op}, 32'd2);
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check_model();

        // Forward from EX/MEM
        drive_instr(1, 5, 6, 9, 32'h10, 32'h20, 0, 2'b00, 6'd0, 1, 1, 0, 0);
        step();
        drive_instr(0, 0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0, 0);
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'h99;
        #1;
        chk("fwd_exm_alu_a", alu_a, 32'h99);
        check_model();
        idle_wb();

        // EX/MEM wins over MEM/WB; MEM/WB used when EX/MEM does not write
        drive_instr(1, 7, 7, 3, 32'h55, 32'h66, 0, 2'b00, 6'd0, 1, 1, 0, 0);
        step();
        drive_instr(0, 0, 0, 0, 0, 0, 0, 2'b00, 6'd0, 0, 0, 0, 0);
        exm_reg_write = 1; exm_rd = 7; exm_result = 32'h1;
        mwb_reg_write = 1; mwb_rd = 7; mwb_result = 32'h2;
        #1;
        chk("prio_exm_a", alu_a, 32'h1);
        chk("prio_exm_b", alu_b, 32'h1);
        exm_reg_write = 0;
        #1;
        chk("prio_mwb_a", alu_a, 32'h2);
        chk("prio_mwb_store", ex_store_data, 32'h2);
        check_model();
        idle_wb();

        // Load-use stall then release with MEM/WB forwarding
        drive_instr(1, 1, 8, 0, 32'h0, 32'h0, 1, 2'b00, 6'd0, 0, 1, 1, 0);
        step();
        drive_instr(1, 8, 2, 3, 32'h111, 32'h222, 0, 2'b10, 6'b100000, 1, 1, 0, 0);
        #1;
        chk("loaduse_stall", {31'd0, stall_id}, 32'd1);
        step();
        chk("loaduse_bubble", {31'd0, ex_valid}, 32'd0);
        chk("loaduse_release", {31'd0, stall_id}, 32'd0);
        mwb_reg_write = 1; mwb_rd = 8; mwb_result = 32'habc;
        step();
        chk("loaduse_issue", {31'd0, ex_valid}, 32'd1);
        chk("loaduse_alu_a", alu_a, 32'habc);
        check_model();
        idle_wb();

        // Flush together with stall gives a single bubble, no re-issue
        drive_instr(1, 1, 9, 0, 32'h0, 32'h0, 1, 2'b00, 6'd0, 0, 1, 1, 0);
        step();
        drive_instr(1, 9, 9, 4, 32'h5, 32'h6, 0, 2'b01, 6'd0, 1, 1, 0, 0);
        flush = 1;
        #1;
        chk("flushstall_stall", {31'd0, stall_id}, 32'd1);
        step();
        chk("flushstall_bubble", {31'd0, ex_valid}, 32'd0);
        flush = 0;
        drive_instr(0, 9, 9, 4, 32'h5, 32'h6, 0, 2'b01, 6'd0, 1, 1, 0, 0);
        step();
        chk("flushstall_noreissue", {31'd0, ex_valid}, 32'd0);
        check_model();

        // Decode corners and register-0 writer
        drive_instr(1, 1, 2, 3, 32'h1, 32'h2, 0, 2'b10, 6'b101010, 1, 1, 0, 0);
        step();
        chk("dec_slt", {29'd0, alu_op}, 32'd7);
        chk("dec_slt_legal", {31'd0, ex_illegal}, 32'd0);
        drive_instr(1, 0, 2, 3, 32'h55, 32'h2, 0, 2'b10, 6'b000011, 1, 1, 0, 0);
        step();
        chk("dec_bad_op", {29'd0, alu_op}, 32'd2);
        chk("dec_bad_illegal", {31'd0, ex_illegal}, 32'd1);
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'hdead;
        mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'hbeef;
        #1;
        chk("reg0_no_fwd", alu_a, 32'h55);
        check_model();
        idle_wb();

        // Reset during a load-use stall
        drive_instr(1, 1, 10, 0, 32'h0, 32'h0, 1, 2'b00, 6'd0, 0, 1, 1, 0);
        step();
        drive_instr(1, 10, 3, 4, 32'h7, 32'h8, 0, 2'b00, 6'd0, 1, 1, 0, 0);
        #1;
        chk("rststall_stall", {31'd0, stall_id}, 32'd1);
        rst = 1;
        step();
        rst = 0;
        chk("rststall_stall_clear", {31'd0, stall_id}, 32'd0);
        chk("rststall_valid", {31'd0, ex_valid}, 32'd0);
        chk("rststall_op", {29'd0, alu_op}, 32'd2);
        chk("rststall_dest", {27'd0, ex_dest}, 32'd0);
        check_model();

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive_instr(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        $urandom, $urandom, 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)),
                        ($urandom_range(0, 1) != 0) ? 6'b100000 + 6'($urandom_range(0, 10)) : 6'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            id_imm = $urandom;
            flush = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 31) == 0);
            exm_reg_write = 1'($urandom_range(0, 1));
            exm_rd = 5'($urandom_range(0, 3));
            exm_result = $urandom;
            mwb_reg_write = 1'($urandom_range(0, 1));
            mwb_rd = 5'($urandom_range(0, 3));
            mwb_result = $urandom;
            #1;
            chk("rand_stall_pre", {31'd0, stall_id}, {31'd0, ref_stall()});
            step();
            check_model();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
